// File: rtl/board_io_top.sv
// Board I/O wrapper: synchronizes and debounces buttons/switches, toggles one LED per
// button press, and reports each press as an 8N1 ASCII byte on UART_TX.
module board_io_top #(
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned DEBOUNCE_CYCLES = 128
) (
  input  logic       CLK100MHZ,
  input  logic       nrst,
  input  logic [3:0] btn_in,
  input  logic [2:0] switch_in,
  output logic [3:0] LED_out,
  output logic       UART_TX
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [3:0]    btn_s1, btn_s2;
  logic [2:0]    sw_s1, sw_s2;
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    rise;
  logic [3:0]    pending;
  logic          sel_valid;
  logic [1:0]    sel_idx;
  logic [3:0]    sel_mask;
  logic          found;
  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge CLK100MHZ or posedge nrst) begin
    if (nrst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      sw_s1  <= switch_in;
      sw_s2  <= sw_s1;
    end
  end

  // A press is recognised in the same cycle the debounced level is updated to 1.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      rise[i] = btn_s2[i] & ~deb[i] & (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge CLK100MHZ or posedge nrst) begin
    if (nrst) begin
      deb <= '0;
      for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= btn_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pending[i] && !found) begin
        found   = 1'b1;
        sel_idx = i[1:0];
      end
    end
    sel_valid = (state == IDLE) && found;
    sel_mask  = sel_valid ? (4'b0001 << sel_idx) : '0;
  end

  always_ff @(posedge CLK100MHZ or posedge nrst) begin
    if (nrst) begin
      LED_out <= '0;
      pending <= '0;
    end else begin
      LED_out <= LED_out ^ rise;
      pending <= (pending & ~sel_mask) | rise;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge nrst) begin
    if (nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      UART_TX  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          UART_TX  <= 1'b1;
          baud_cnt <= '0;
          if (sel_valid) begin
            shreg   <= 8'h30 + {3'b000, sw_s2, sel_idx};
            UART_TX <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            UART_TX  <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              UART_TX <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_io_top.sv
// Directed bench for board_io_top: LED toggling, debounce latency, glitch rejection,
// UART framing of queued presses, and reset in the middle of a frame.
module tb_board_io_top;

  localparam int unsigned CPB = 32;
  localparam int unsigned DEB = 128;

  logic       clk;
  logic       nrst;
  logic [3:0] btn;
  logic [2:0] sw;
  logic [3:0] led;
  logic       tx;

  int n_tests = 0;
  int n_fail  = 0;

  board_io_top #(.CLKS_PER_BIT(CPB), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK100MHZ(clk),
    .nrst     (nrst),
    .btn_in   (btn),
    .switch_in(sw),
    .LED_out  (led),
    .UART_TX  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polls for the start bit, then samples each bit in its middle.
  task automatic uart_rx(output logic [7:0] b, output int gap, output logic tmo);
    gap = 0;
    tmo = 1'b0;
    b   = '0;
    while (tx !== 1'b0 && gap < 4000) begin
      @(negedge clk);
      gap++;
    end
    if (tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    check("start_bit", {31'd0, tx}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", {31'd0, tx}, 32'd1);
  endtask

  task automatic watch_idle(input int n, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  // Drives a press at a negedge and returns cycles until the LEDs change.
  task automatic press(input logic [3:0] mask, output int lat, output logic [3:0] led_new);
    logic [3:0] prev;
    prev = led;
    lat  = 0;
    btn  = mask;
    while (led === prev && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    led_new = led;
  endtask

  task automatic release_after(input int n);
    fork
      begin
        repeat (n) @(negedge clk);
        btn = 4'b0000;
      end
    join_none
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] led_new;
    int         gap, lat, lows;
    logic       tmo;

    nrst = 1'b1;
    btn  = 4'b0000;
    sw   = 3'b000;
    repeat (5) @(negedge clk);
    check("reset_led_during", {28'd0, led}, 32'h0);
    check("reset_tx_during", {31'd0, tx}, 32'd1);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("reset_led_after", {28'd0, led}, 32'h0);
    watch_idle(500, lows);
    check("idle_no_activity", lows, 0);
    check("idle_led", {28'd0, led}, 32'h0);

    // Single press of button 0, switches 000 -> '0'
    press(4'b0001, lat, led_new);
    check("press_lat_in_range", {31'd0, (lat >= 130 && lat <= 132)}, 32'd1);
    check("press_led", {28'd0, led_new}, 32'h1);
    release_after(210 - lat);
    @(negedge clk);
    check("press_to_start", {31'd0, tx}, 32'd0);
    uart_rx(b, gap, tmo);
    check("rx1_timeout", {31'd0, tmo}, 32'd0);
    check("rx1_byte", {24'd0, b}, 32'h30);
    repeat (CPB + 300) @(negedge clk);

    // Button 2 with switches 101 -> 0x46
    sw = 3'b101;
    repeat (5) @(negedge clk);
    press(4'b0100, lat, led_new);
    check("press2_led", {28'd0, led_new}, 32'h5);
    release_after(210 - lat);
    uart_rx(b, gap, tmo);
    check("rx2_timeout", {31'd0, tmo}, 32'd0);
    check("rx2_byte", {24'd0, b}, 32'h46);
    repeat (CPB + 300) @(negedge clk);

    // 50-cycle glitch on button 1 must be ignored
    btn = 4'b0010;
    repeat (50) @(negedge clk);
    btn = 4'b0000;
    watch_idle(400, lows);
    check("glitch_no_frame", lows, 0);
    check("glitch_led", {28'd0, led}, 32'h5);

    // Simultaneous buttons 0 and 3 -> back-to-back 0x30, 0x33
    sw = 3'b000;
    repeat (5) @(negedge clk);
    press(4'b1001, lat, led_new);
    check("queued_led", {28'd0, led_new}, 32'hC);
    release_after(210 - lat);
    uart_rx(b, gap, tmo);
    check("rxq1_timeout", {31'd0, tmo}, 32'd0);
    check("rxq1_byte", {24'd0, b}, 32'h30);
    uart_rx(b, gap, tmo);
    check("rxq2_timeout", {31'd0, tmo}, 32'd0);
    check("rxq2_byte", {24'd0, b}, 32'h33);
    check("rxq2_gap", gap, CPB / 2 + 1);
    repeat (CPB + 300) @(negedge clk);

    // Reset in the middle of the DATA phase
    press(4'b0001, lat, led_new);
    check("mid_led", {28'd0, led_new}, 32'hD);
    release_after(210 - lat);
    lows = 0;
    while (tx !== 1'b0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check("mid_start_seen", {31'd0, tx}, 32'd0);
    repeat (CPB * 4) @(negedge clk);
    nrst = 1'b1;
    #1;
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_led", {28'd0, led}, 32'h0);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    watch_idle(CPB * 12, lows);
    check("post_reset_quiet", lows, 0);

    // Fresh press after reset still works
    press(4'b0001, lat, led_new);
    check("post_reset_led", {28'd0, led_new}, 32'h1);
    release_after(210 - lat);
    uart_rx(b, gap, tmo);
    check("rx_post_timeout", {31'd0, tmo}, 32'd0);
    check("rx_post_byte", {24'd0, b}, 32'h30);
    repeat (CPB) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_io_top.md
# board_io_top

Board-level I/O controller for the 100 MHz FPGA demo target. It synchronizes and debounces four push-buttons and three slide switches, toggles one LED per button, and reports each accepted button press as one 8N1 ASCII byte on a UART transmit line. It sits directly on the board pins as the design's top-level wrapper.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (115200 baud at 100 MHz).
- DEBOUNCE_CYCLES, default 128: consecutive stable synchronized samples required to accept a button level change.

Ports:
- CLK100MHZ  input  1  100 MHz system clock; all logic on rising edge.
- nrst  input  1  reset, asynchronous, active-high; clears all state.
- btn_in  input  4  raw push-buttons, active-high, asynchronous to the clock.
- switch_in  input  3  raw slide switches, asynchronous to the clock.
- LED_out  output  4  LED drive, one bit per button.
- UART_TX  output  1  UART serial output, idle high.

## Operation
- Synchronization: btn_in and switch_in each pass through a 2-flop synchronizer; only synchronized values are used.
- Debounce, per button: counter resets on any mismatch between the synchronized level and the debounced level. The debounced level takes the synchronized value when the counter reaches DEBOUNCE_CYCLES. A press event is a 0->1 transition of the debounced level. Releases generate no event.
- LEDs: LED_out[i] toggles on each press event of button i.
- Pending mask: 4-bit register. A press event on button i sets bit i. Simultaneous events set all corresponding bits. A second press of button i while bit i is still set is merged into that bit (the LED still toggles).
- Byte selection: when the transmitter is idle and the mask is non-zero, the lowest set index i is selected and its bit is cleared in the same cycle.
  - Byte = 8'h30 + {sw, i[1:0]}, where sw is the synchronized switch_in captured at selection.
  - Range is 0x30..0x4F. Example: switches 0, button 0 gives 0x30 ('0').
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TX=1. On selection, go to START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The transmitter can accept the next byte in the cycle after STOP completes.
- Reset values: LED_out=4'b0000, UART_TX=1, FSM=IDLE, pending mask=0, debounced levels=0, all counters=0.
- Reset mid-frame aborts the frame immediately: UART_TX returns to 1 and queued events are discarded.

## Timing
- Press-to-LED latency: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 register cycle after a stable high input. With defaults this is 131 cycles ±1.
- Press-to-start-bit: 1 cycle after the press event when the transmitter is idle.
- Frame length: 10 × CLKS_PER_BIT cycles (8680 with the default, 86.8 µs).
- Minimum accepted pulse width: DEBOUNCE_CYCLES+2 cycles. A 210-cycle press is accepted. Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Bit counter and baud counter restart at 0 on every state entry. There is no drift across bits.
- Outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset: hold nrst=1 for 10 cycles -> LED_out=0000 and UART_TX=1 during and after reset; no activity for 50 µs with idle inputs.
- Single press: switch_in=000, btn_in=0001 for 2100 ns -> LED_out=0001 about 131 cycles after assertion. UART frame: start bit, bits of 0x30 LSB first, stop bit; each bit 868 cycles.
- Second button with switches: switch_in=101, btn_in=0100 for 2100 ns, 1 ms after the first press -> LED_out=0101; byte 0x30+(5×4+2)=0x46.
- Glitch rejection: btn_in=0010 for 50 cycles -> LED_out unchanged and no UART frame.
- Queued events: btn_in=1001 pressed simultaneously -> LED_out toggles bits 0 and 3 in the same cycle. Two back-to-back frames go out, 0x30 then 0x33, separated by no idle gap beyond 1 cycle.
- Reset mid-frame: assert nrst halfway through the DATA state -> UART_TX=1 immediately; no frame after release until a new press.
